// File: rtl/clz_normalizer.sv
// Iterative count-leading-zeros/ones and left-normalize: 16/8/4/2/1 binary search, one step per cycle.
// Optional macro CLZ_EARLY_EXIT_EN: single-cycle result when the leading run is 0 or 32.
module clz_normalizer #(
   parameter logic MODE_CLZ = 1'b0,
   parameter logic MODE_CLO = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] D,
   input  logic        MODE,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  CNT,
   output logic [31:0] N
);

   typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] w_q, w_d;
   logic        lead_q, lead_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [2:0]  k_q, k_d;
   logic [5:0]  cnt_out_q, cnt_out_d;
   logic [31:0] n_out_q, n_out_d;

   logic        lead_in;
   logic [4:0]  field_match;
   logic [4:0]  step_amt;
   logic [31:0] step_w;
   logic [5:0]  step_cnt;

   always_comb begin
      case (MODE)
         MODE_CLO: lead_in = 1'b1;
         MODE_CLZ: lead_in = 1'b0;
         default:  lead_in = 1'b0;
      endcase
   end

   // field_match[gi]: the top 2^gi bits of W all equal the lead bit.
   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_field
         assign field_match[gi] = &(~(w_q[31 -: (1 << gi)] ^ {(1 << gi){lead_q}}));
      end
   endgenerate

   assign step_amt = 5'd1 << k_q;
   assign step_w   = field_match[k_q] ? (w_q << step_amt) : w_q;
   assign step_cnt = field_match[k_q] ? (cnt_q + {1'b0, step_amt}) : cnt_q;

   always_comb begin
      state_d   = state_q;
      w_d       = w_q;
      lead_d    = lead_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      cnt_out_d = cnt_out_q;
      n_out_d   = n_out_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               w_d     = D;
               lead_d  = lead_in;
               cnt_d   = 6'd0;
               k_d     = 3'd4;
               state_d = STEP;
`ifdef CLZ_EARLY_EXIT_EN
               if (D[31] != lead_in) begin
                  state_d   = DONE;
                  cnt_out_d = 6'd0;
                  n_out_d   = D;
               end else if (D == {32{lead_in}}) begin
                  state_d   = DONE;
                  cnt_out_d = 6'd32;
                  n_out_d   = 32'd0;
               end
`endif
            end
         end
         STEP: begin
            w_d   = step_w;
            cnt_d = step_cnt;
            k_d   = k_q - 3'd1;
            if (k_q == 3'd0) begin
               state_d = DONE;
               k_d     = 3'd4;
               // Greedy search saturates at 31; a still-matching top bit means the run was 32.
               if (step_w[31] == lead_q) begin
                  cnt_out_d = 6'd32;
                  n_out_d   = 32'd0;
               end else begin
                  cnt_out_d = step_cnt;
                  n_out_d   = step_w;
               end
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         w_q       <= 32'd0;
         lead_q    <= 1'b0;
         cnt_q     <= 6'd0;
         k_q       <= 3'd4;
         cnt_out_q <= 6'd0;
         n_out_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         w_q       <= w_d;
         lead_q    <= lead_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         cnt_out_q <= cnt_out_d;
         n_out_q   <= n_out_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign CNT       = cnt_out_q;
   assign N         = n_out_q;

endmodule

// File: tb/tb_clz_normalizer.sv
// Directed bench for clz_normalizer: vector table plus backpressure, mid-step reset and back-to-back sequences.
module tb_clz_normalizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] D;
   logic        MODE;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  CNT;
   logic [31:0] N;

   int pass_cnt = 0;
   int total_cnt = 0;

   clz_normalizer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .D         (D),
      .MODE      (MODE),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .CNT       (CNT),
      .N         (N)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic        mode;
      logic [5:0]  cnt;
      logic [31:0] n;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic int exp_lat(input logic [31:0] d, input logic m);
`ifdef CLZ_EARLY_EXIT_EN
      if (d[31] != m || d == {32{m}}) return 1;
`endif
      return 6;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one operand with out_ready held high and check result, latency and handshake.
   task automatic run_op(input int idx, input logic [31:0] d, input logic m,
                         input logic [5:0] ecnt, input logic [31:0] en);
      int lat;
      int guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      chk($sformatf("v%0d_in_ready_before", idx), 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      D         = d;
      MODE      = m;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_in_ready_busy", idx), 32'(in_ready), 32'd0);
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      $display("vec %0d: D=0x%08h MODE=%0d -> CNT=%0d N=0x%08h latency=%0d",
               idx, d, m, CNT, N, lat);
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(exp_lat(d, m)));
      chk($sformatf("v%0d_CNT", idx), 32'(CNT), 32'(ecnt));
      chk($sformatf("v%0d_N", idx), N, en);
      tick();
      chk($sformatf("v%0d_out_valid_drop", idx), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_in_ready_after", idx), 32'(in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      int nvalid;
      int nres;
      logic        b_sent;
      logic [5:0]  rcnt[2];
      logic [31:0] rn[2];

      vecs[0]  = '{32'h00F00000, 1'b0, 6'd8,  32'hF0000000};
      vecs[1]  = '{32'h00000000, 1'b0, 6'd32, 32'h00000000};
      vecs[2]  = '{32'hFFFFFFFF, 1'b1, 6'd32, 32'h00000000};
      vecs[3]  = '{32'h00000001, 1'b0, 6'd31, 32'h80000000};
      vecs[4]  = '{32'hFFFF0001, 1'b1, 6'd16, 32'h00010000};
      vecs[5]  = '{32'h80000000, 1'b0, 6'd0,  32'h80000000};
      vecs[6]  = '{32'h00000100, 1'b0, 6'd23, 32'h80000000};
      vecs[7]  = '{32'h7FFFFFFF, 1'b1, 6'd0,  32'h7FFFFFFF};
      vecs[8]  = '{32'h7FFFFFFF, 1'b0, 6'd1,  32'hFFFFFFFE};
      vecs[9]  = '{32'hFFFFFFFE, 1'b1, 6'd31, 32'h00000000};
      vecs[10] = '{32'h0000FFFF, 1'b0, 6'd16, 32'hFFFF0000};
      vecs[11] = '{32'hC0000000, 1'b1, 6'd2,  32'h00000000};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      D         = 32'd0;
      MODE      = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_CNT", 32'(CNT), 32'd0);
      chk("reset_N", N, 32'd0);

      for (int i = 0; i < 12; i++)
         run_op(i, vecs[i].d, vecs[i].mode, vecs[i].cnt, vecs[i].n);

      // Backpressure: result held for 3 cycles, in_valid pulses ignored.
      in_valid  = 1'b1;
      D         = 32'h00F00000;
      MODE      = 1'b0;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("bp_latency", 32'(lat), 32'(exp_lat(32'h00F00000, 1'b0)));
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         D        = 32'h00000001;
         MODE     = 1'b1;
         tick();
         $display("bp cycle %0d: out_valid=%0d CNT=%0d N=0x%08h in_ready=%0d",
                  c, out_valid, CNT, N, in_ready);
         chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d_CNT", c), 32'(CNT), 32'd8);
         chk($sformatf("bp%0d_N", c), N, 32'hF0000000);
         chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_hold_CNT", 32'(CNT), 32'd8);
      chk("bp_hold_N", N, 32'hF0000000);
      tick();
      chk("bp_no_ghost_op", 32'(out_valid), 32'd0);

      // Reset during the k=2 step discards the operation.
      in_valid = 1'b1;
      D        = 32'h00000003;
      MODE     = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      $display("reset mid-step: in_ready=%0d out_valid=%0d CNT=%0d N=0x%08h",
               in_ready, out_valid, CNT, N);
      chk("rst_step_in_ready", 32'(in_ready), 32'd1);
      chk("rst_step_out_valid", 32'(out_valid), 32'd0);
      chk("rst_step_CNT", 32'(CNT), 32'd0);
      chk("rst_step_N", N, 32'd0);
      nvalid = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (out_valid) nvalid++;
      end
      chk("rst_step_no_result", 32'(nvalid), 32'd0);

      // Back-to-back with out_ready held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      D         = 32'h00000100;
      MODE      = 1'b0;
      tick();
      D      = 32'h7FFFFFFF;
      MODE   = 1'b1;
      b_sent = 1'b0;
      nvalid = 0;
      nres   = 0;
      for (int c = 0; c < 25; c++) begin
         tick();
         if (out_valid) begin
            nvalid++;
            if (nres < 2) begin
               rcnt[nres] = CNT;
               rn[nres]   = N;
               $display("b2b result %0d: CNT=%0d N=0x%08h", nres, CNT, N);
            end
            nres++;
         end
         if (in_ready && !b_sent) b_sent = 1'b1;
         else if (b_sent && !in_ready) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      chk("b2b_valid_cycles", 32'(nvalid), 32'd2);
      if (nres >= 2) begin
         chk("b2b_r0_CNT", 32'(rcnt[0]), 32'd23);
         chk("b2b_r0_N", rn[0], 32'h80000000);
         chk("b2b_r1_CNT", 32'(rcnt[1]), 32'd0);
         chk("b2b_r1_N", rn[1], 32'h7FFFFFFF);
      end else begin
         chk("b2b_result_count", 32'(nres), 32'd2);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/clz_normalizer.md
Name: clz_normalizer

Overview:
- Multi-cycle count-leading-zeros/ones and normalize unit for the ALU; serves MIPS CLZ/CLO and software normalization.
- Performs the inverse of the barrel shifter. The shifter takes a value and an amount and produces a shifted value. This block takes a value and produces the left-shift amount that removes the leading run, plus the left-justified result.
- Iterative binary search over 16/8/4/2/1 bit steps, one step per cycle, with a valid/ready handshake on both sides.

Parameters:
- MODE_CLZ, 1'b0, MODE encoding: count leading zeros.
- MODE_CLO, 1'b1, MODE encoding: count leading ones.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand D/MODE valid.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- D  input  32  operand.
- MODE  input  1  MODE_CLZ or MODE_CLO; sampled at accept.
- out_valid  output  1  CNT/N valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- CNT  output  6  leading-run length, 0..32.
- N  output  32  D << CNT, zero-filled; 0 when CNT=32.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: rst_n sampled low at a rising edge of clk resets the block.
- States: IDLE, STEP, DONE.
- Reset (synchronous, rst_n low at edge):
  - state=IDLE.
  - out_valid=0, CNT=0, N=0, internal step index=4.
  - in_ready=1 from the following cycle.
  - Applies from any state, including mid-STEP or DONE; the in-flight operation is discarded with no output.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge t: latch W=D, lead bit L=MODE (0 for CLZ, 1 for CLO), cnt=0, k=4; go to STEP.
  - in_valid without acceptance has no effect.
- STEP, cycles t+1..t+5, k=4,3,2,1,0:
  - If W[31:32-2^k] are all equal to L: W <= W<<2^k (zero fill), cnt <= cnt+2^k.
  - Then k decrements.
  - In the k=0 cycle, after the step, if the shifted W[31]==L then the input was all L: CNT=32, N=0. Otherwise CNT=cnt, N=W.
  - Go to DONE.
- DONE:
  - out_valid=1 from t+6; worst-case latency 6 cycles accept-to-valid.
  - CNT/N stable while out_ready=0.
  - in_ready=0.
  - On out_valid&&out_ready at edge: out_valid <= 0, go IDLE; in_ready=1 next cycle.
  - No same-cycle accept of a new operand.
- CNT/N hold their last value after handshake until the next result; only out_valid qualifies them.
- in_valid, D and MODE are ignored outside IDLE.
- MODE is ignored after accept.
- Arithmetic: cnt is a 6-bit accumulator; the greedy search yields min(run,31); the 32 case is detected only by the final W[31] check.

Optional Feature:
- Macro CLZ_EARLY_EXIT_EN.
- Defined, at accept:
  - If D[31]!=L: go directly to DONE with CNT=0, N=D; out_valid at t+1.
  - If D is all L (0x00000000 for CLZ, 0xFFFFFFFF for CLO): DONE with CNT=32, N=0; out_valid at t+1.
  - Otherwise normal STEP sequence, latency 6.
- Undefined: every operand takes the full 6-cycle latency.
- Results are identical either way; only latency differs.

Test Plan:
- D=0x00F00000, MODE=CLZ accepted at t -> out_valid at t+6, CNT=8, N=0xF0000000; in_ready low t+1..handshake.
- D=0x00000000 CLZ -> CNT=32, N=0. D=0xFFFFFFFF CLO -> CNT=32, N=0. D=0x00000001 CLZ -> CNT=31, N=0x80000000.
- D=0xFFFF0001 CLO -> CNT=16, N=0x00010000. D=0x80000000 CLZ -> CNT=0, N=0x80000000 (latency t+1 with CLZ_EARLY_EXIT_EN, else t+6).
- Backpressure: out_ready=0 for 3 cycles after out_valid -> CNT/N/out_valid stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- rst_n=0 for one edge during STEP k=2 -> next cycle state IDLE, out_valid=0, CNT=0, N=0, in_ready=1; no result ever emitted for the aborted operand.
- Back-to-back: 0x00000100 CLZ then 0x7FFFFFFF CLO with out_ready=1 held -> CNT=23/N=0x80000000, then CNT=0/N=0x7FFFFFFF, each exactly one out_valid cycle.
